gp_regfile: RTL

//  Parametrised general-purpose register file, next generation of the r0..r7 bank.

---
 rtl/gp_regfile_pkg.sv | 22 ++
 rtl/gp_regfile_rf_read_port.sv | 47 ++++
 rtl/gp_regfile.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gp_regfile_pkg.sv
// Shared lane / stack-op encodings for the gp_regfile register bank.
package gp_regfile_pkg;

  typedef enum logic [1:0] {
    LANE_NONE = 2'b00,
    LANE_LO   = 2'b01,
    LANE_HI   = 2'b10,
    LANE_FULL = 2'b11
  } lane_e;

  typedef enum logic [1:0] {
    SP_IDLE = 2'b00,
    SP_PUSH = 2'b01,
    SP_RSVD = 2'b10,
    SP_POP  = 2'b11
  } sp_op_e;

  function automatic logic is_half(input logic [1:0] lane);
    return (lane == LANE_HI) || (lane == LANE_LO);
  endfunction

endpackage

// File: rtl/gp_regfile_rf_read_port.sv
// One registered read port: index mux over the flat bank, lane extract, output flop.
module rf_read_port
  import gp_regfile_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int WIDTH = 16,
  parameter int SELW  = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREG*WIDTH-1:0] i_regs_flat,
  input  logic [SELW-1:0]       i_sel,
  input  logic [1:0]            i_lane,
  output logic [WIDTH-1:0]      o_data
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_fmt;
  logic [WIDTH-1:0] r_data;

  assign w_word = i_regs_flat[i_sel*WIDTH +: WIDTH];

  // Lane formatting; half reads are zero-extended into the low half
  always_comb begin
    w_fmt = '0;
    case (i_lane)
      LANE_FULL: w_fmt = w_word;
      LANE_HI:   w_fmt = {{HW{1'b0}}, w_word[WIDTH-1:HW]};
      LANE_LO:   w_fmt = {{HW{1'b0}}, w_word[HW-1:0]};
      default:   w_fmt = '0;
    endcase
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_fmt;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/gp_regfile.sv
// Parametrised register bank with byte-lane writes, per-lane arbitration and registered reads.
// Optional macro SP_AUTO_EN enables stack-pointer push/pop on register SP_IDX.
module gp_regfile
  import gp_regfile_pkg::*;
#(
  parameter int               NREG      = 8,
  parameter int               WIDTH     = 16,
  parameter int               NPORT     = 2,
  parameter int               HALF_REGS = 4,
  parameter int               SP_IDX    = 7,
  parameter int               SP_STEP   = 2,
  parameter logic [WIDTH-1:0] SP_INIT   = 16'hFFFE,
  localparam int              SELW      = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT-1:0]       wr_en,
  input  logic [NPORT*SELW-1:0]  wr_sel,
  input  logic [NPORT*2-1:0]     wr_lane,
  input  logic [NPORT*WIDTH-1:0] wr_data,
  input  logic [NPORT*SELW-1:0]  rd_sel,
  input  logic [NPORT*2-1:0]     rd_lane,
  output logic [NPORT*WIDTH-1:0] rd_data,
  output logic [NREG*WIDTH-1:0]  regs_flat,
  input  logic [1:0]             sp_op,
  output logic                   conflict,
  output logic                   lane_err
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] w_next [NREG];
  logic [HW-1:0]    w_hi_d [NREG];
  logic [HW-1:0]    w_lo_d [NREG];
  logic [NREG-1:0]  w_hi_we;
  logic [NREG-1:0]  w_lo_we;
  logic [1:0]       w_lane;
  logic             w_sel_hit;
  logic             w_hit_hi;
  logic             w_hit_lo;
  logic             w_conflict;
  logic             w_lane_err;
  logic             r_conflict;
  logic             r_lane_err;

  // Per-lane arbitration: ascending port scan so the highest index port wins
  always_comb begin
    w_hi_we    = '0;
    w_lo_we    = '0;
    w_conflict = 1'b0;
    w_lane_err = 1'b0;
    w_lane     = 2'b00;
    w_sel_hit  = 1'b0;
    w_hit_hi   = 1'b0;
    w_hit_lo   = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_hi_d[i] = '0;
      w_lo_d[i] = '0;
      for (int p = 0; p < NPORT; p++) begin
        w_lane     = wr_lane[p*2 +: 2];
        w_sel_hit  = wr_en[p] && (wr_sel[p*SELW +: SELW] == SELW'(i));
        w_hit_hi   = w_sel_hit && ((w_lane == LANE_FULL) || ((w_lane == LANE_HI) && (i < HALF_REGS)));
        w_hit_lo   = w_sel_hit && ((w_lane == LANE_FULL) || ((w_lane == LANE_LO) && (i < HALF_REGS)));
        w_lane_err = w_lane_err | (w_sel_hit && (i >= HALF_REGS) && is_half(w_lane));
        w_conflict = w_conflict | (w_hit_hi & w_hi_we[i]) | (w_hit_lo & w_lo_we[i]);
        w_hi_d[i]  = !w_hit_hi ? w_hi_d[i] :
                     (w_lane == LANE_FULL) ? wr_data[p*WIDTH+HW +: HW] : wr_data[p*WIDTH +: HW];
        w_lo_d[i]  = w_hit_lo ? wr_data[p*WIDTH +: HW] : w_lo_d[i];
        w_hi_we[i] = w_hi_we[i] | w_hit_hi;
        w_lo_we[i] = w_lo_we[i] | w_hit_lo;
      end
    end
  end

`ifdef SP_AUTO_EN
  logic [WIDTH-1:0] w_sp_adj;

  // Stack adjust, wrapping modulo 2^WIDTH
  always_comb begin
    w_sp_adj = r_regs[SP_IDX];
    case (sp_op)
      SP_PUSH: w_sp_adj = r_regs[SP_IDX] - WIDTH'(SP_STEP);
      SP_POP:  w_sp_adj = r_regs[SP_IDX] + WIDTH'(SP_STEP);
      default: w_sp_adj = r_regs[SP_IDX];
    endcase
  end
`endif

  // Next-state merge; an explicit port write to SP overrides the stack op
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_next[i] = {w_hi_we[i] ? w_hi_d[i] : r_regs[i][WIDTH-1:HW],
                   w_lo_we[i] ? w_lo_d[i] : r_regs[i][HW-1:0]};
    end
`ifdef SP_AUTO_EN
    w_next[SP_IDX] = (w_hi_we[SP_IDX] || w_lo_we[SP_IDX]) ? w_next[SP_IDX] : w_sp_adj;
`endif
  end

  // Register bank and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
`ifdef SP_AUTO_EN
      r_regs[SP_IDX] <= SP_INIT;
`endif
      r_conflict <= 1'b0;
      r_lane_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= w_next[i];
      end
      r_conflict <= w_conflict;
      r_lane_err <= w_lane_err;
    end
  end

  assign conflict = r_conflict;
  assign lane_err = r_lane_err;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
  end

  for (genvar g = 0; g < NPORT; g++) begin : g_rd
    rf_read_port #(
      .NREG  (NREG),
      .WIDTH (WIDTH),
      .SELW  (SELW)
    ) u_rd (
      .clk         (clk),
      .rst         (rst),
      .i_regs_flat (regs_flat),
      .i_sel       (rd_sel[g*SELW +: SELW]),
      .i_lane      (rd_lane[g*2 +: 2]),
      .o_data      (rd_data[g*WIDTH +: WIDTH])
    );
  end

endmodule
